// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit slice reused NSLICE times, LSB nibble first.
// Ports: clk, rst (sync, active-high), start/a/b/cin in; busy/done/sum/cout out.
// Optional macro ADD_SUB_EN adds input 'sub' (a - b as a + ~b + 1).
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic [4:0]       nib;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             last;

  // Operand conditioning at acceptance: subtract inverts B and forces carry.
`ifdef ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign last = (idx == IW'(NSLICE - 1));

  // The single 4-bit slice plus the accumulator image including this nibble,
  // so the final pass can publish the whole result in one edge.
  always_comb begin
    nib = {1'b0, a_q[{idx, 2'b00} +: 4]}
        + {1'b0, b_q[{idx, 2'b00} +: 4]}
        + {4'b0, carry};
    acc_n = acc;
    acc_n[{idx, 2'b00} +: 4] = nib[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_n;
          carry <= nib[4];
          idx   <= idx + 1'b1;
          if (last) begin
            sum   <= acc_n;
            cout  <= nib[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
